// File: rtl/mem_l2_responder_pkg.sv
// Shared types and constants for the L2 <-> memory interface.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_l2_responder_pkg;

   localparam int LINE_W = 512;   // one cache line
   localparam int ADDR_W = 26;    // line address, byte address bits [31:6]
   localparam int CNT_W  = 4;     // holds LATENCY-1 for LATENCY up to 15

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Counter preload: BUSY counts down to zero, then RESP follows, so the
   // accept-to-response distance becomes lat+1 edges.
   function automatic logic [CNT_W-1:0] lat_load(input int lat);
      return CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/mem_line_array.sv
// Line storage for the memory model: single port, combinational read, synchronous write.
// Latency: write commits on the edge with we high; read data follows addr in the same cycle.
// Backpressure: none, always accepts a write.
// Ports: clk/rst (sync, active-high, clears all lines), we, addr (line index),
//        wdata (line to store), rdata (line at addr).
module mem_line_array
   import mem_l2_responder_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [LINE_W-1:0] wdata,
   output logic [LINE_W-1:0] rdata
);

   logic [LINE_W-1:0] lines [DEPTH];

   // One register per line so reset can clear every line in the same edge.
   for (genvar g = 0; g < DEPTH; g++) begin : g_line
      always_ff @(posedge clk) begin
         if (rst) begin
            lines[g] <= '0;
         end else if (we && (addr == IDX_W'(g))) begin
            lines[g] <= wdata;
         end
      end
   end

   assign rdata = lines[addr];

endmodule

// File: rtl/mem_l2_responder.sv
// Fixed-latency memory responder for L2 refills (reads) and writebacks (writes).
// Latency: resp_valid_MEM_L2 is sampled high LATENCY+1 edges after the accept edge.
// Backpressure: one request in flight; req_ready_MEM_L2 high only in IDLE, other offers dropped.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_we/addr/write_data from L2;
//        read_data_MEM_L2 (held until next read response), resp_valid_MEM_L2 (1-cycle pulse).
module mem_l2_responder
   import mem_l2_responder_pkg::*;
#(
   parameter int LATENCY = 4,
   parameter int DEPTH   = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_L2_MEM,
   output logic              req_ready_MEM_L2,
   input  logic              req_we_L2_MEM,
   input  logic [ADDR_W-1:0] addr_L2_MEM,
   input  logic [LINE_W-1:0] write_data_L2_MEM,
   output logic [LINE_W-1:0] read_data_MEM_L2,
   output logic              resp_valid_MEM_L2
);

   localparam int IDX_W = $clog2(DEPTH);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              we_q;
   logic [IDX_W-1:0]  idx_q;
   logic [LINE_W-1:0] wdata_q;
   logic              arr_we;
   logic [LINE_W-1:0] arr_rdata;

   // Upper line-address bits deliberately alias onto the array.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr_L2_MEM[ADDR_W-1:IDX_W];

   // The write lands on the edge that enters RESP; a reset on that edge wins
   // inside the array, so an aborted write never commits.
   assign arr_we = (state == ST_BUSY) && (cnt == '0) && we_q;

   mem_line_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (arr_we),
      .addr  (idx_q),
      .wdata (wdata_q),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= ST_IDLE;
         cnt               <= '0;
         we_q              <= 1'b0;
         idx_q             <= '0;
         wdata_q           <= '0;
         req_ready_MEM_L2  <= 1'b1;
         resp_valid_MEM_L2 <= 1'b0;
         read_data_MEM_L2  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               resp_valid_MEM_L2 <= 1'b0;
               if (req_valid_L2_MEM && req_ready_MEM_L2) begin
                  // Everything the operation needs is captured here, so later
                  // input changes cannot disturb it.
                  we_q             <= req_we_L2_MEM;
                  idx_q            <= addr_L2_MEM[IDX_W-1:0];
                  wdata_q          <= write_data_L2_MEM;
                  cnt              <= lat_load(LATENCY);
                  req_ready_MEM_L2 <= 1'b0;
                  state            <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (cnt == '0) begin
                  state             <= ST_RESP;
                  resp_valid_MEM_L2 <= 1'b1;
                  if (!we_q) begin
                     read_data_MEM_L2 <= arr_rdata;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RESP: begin
               resp_valid_MEM_L2 <= 1'b0;
               req_ready_MEM_L2  <= 1'b1;
               state             <= ST_IDLE;
            end
            default: begin
               resp_valid_MEM_L2 <= 1'b0;
               req_ready_MEM_L2  <= 1'b1;
               state             <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_l2_responder.md
MEM_L2_RESPONDER -- requirements
Module: mem_l2_responder

Interface
REQ-001 Parameter LATENCY, default 4, cycles from request accept to response (legal 1..15).
REQ-002 Parameter DEPTH, default 256, number of 512-bit lines held (power of two).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid_L2_MEM  input  1  L2 presents a request this cycle.
REQ-006 req_ready_MEM_L2  output  1  responder can accept a request this cycle.
REQ-007 req_we_L2_MEM  input  1  1 = writeback, 0 = refill read.
REQ-008 addr_L2_MEM  input  26  line address (byte address bits [31:6]).
REQ-009 write_data_L2_MEM  input  512  writeback line from L2 data array.
REQ-010 read_data_MEM_L2  output  512  refill line to L2 data array.
REQ-011 resp_valid_MEM_L2  output  1  one-cycle completion pulse (read data valid or write committed).

Function
REQ-012 States IDLE, BUSY, RESP; encoding from shared package.
REQ-013 Accept occurs when req_valid_L2_MEM and req_ready_MEM_L2 are both high at a rising edge.
REQ-014 req_ready_MEM_L2 SHALL be high only in IDLE; requests offered in BUSY or RESP are ignored, not queued.
REQ-015 On accept: latch we, addr index, and write data; load latency counter with LATENCY-1; go to BUSY.
REQ-016 BUSY: decrement counter each cycle; at 0 go to RESP.
REQ-017 RESP: resp_valid_MEM_L2 high exactly one cycle; next state IDLE.
REQ-018 Accept-to-resp_valid latency SHALL be exactly LATENCY+1 cycles (accept edge to the edge at which resp_valid is first sampled high).
REQ-019 Read: read_data_MEM_L2 SHALL show the line at the latched index during the RESP cycle and hold it until the next read response.
REQ-020 Write: array line updated with the latched data on the RESP-entering edge; read_data_MEM_L2 unchanged by writes.
REQ-021 Index = addr_L2_MEM[log2(DEPTH)-1:0]; upper address bits ignored (aliasing/wrap-around is intended).
REQ-022 Read following write to same index SHALL return the newly written data.
REQ-023 A new request may be accepted in the IDLE cycle right after RESP; minimum issue interval LATENCY+2 cycles.
REQ-024 Changes on request inputs after accept SHALL not affect the in-flight operation.

Reset
REQ-025 rst high at an edge: state IDLE, counter 0, resp_valid_MEM_L2 0, read_data_MEM_L2 0, req_ready_MEM_L2 1 after release.
REQ-026 All array lines SHALL reset to 512'h0.
REQ-027 Reset during BUSY/RESP aborts: no array write, no resp pulse.
REQ-028 Request presented with rst high is not accepted.

Structure
REQ-029 Shared package holds state typedef, LINE_W=512, ADDR_W=26 constants, shared with L2 modules.
REQ-030 Storage SHALL be a separate sub-module mem_line_array (single port, synchronous write, reset clear).

Verification
REQ-031 Reset, then read addr 26'h5 -> resp_valid at accept+5 (LATENCY=4), data 512'h0.
REQ-032 Write addr 26'h12 data {16{32'hDEADBEEF}}, then read 26'h12 -> resp after write, data matches.
REQ-033 Write addr 26'h100 (DEPTH=256) data A, read addr 26'h0 -> returns A (wrap-around).
REQ-034 req_valid held high continuously for 3 requests -> exactly one accept per LATENCY+2 cycles, ready low while busy.
REQ-035 Assert rst two cycles into write of data B to 26'h7 -> no resp_valid; later read 26'h7 returns 512'h0.
REQ-036 Change addr/data inputs during BUSY -> response reflects latched values only.
